// File: rtl/request_encoder_16_4_pkg.sv
// Shared constants and helpers for the 16-to-4 request encoder.
// Provides widths and a 4-bit index to 16-bit one-hot helper.
package request_encoder_16_4_pkg;

  localparam int REQ_WIDTH = 16;
  localparam int IDX_WIDTH = 4;

  function automatic logic [REQ_WIDTH-1:0] onehot16(
    input logic [IDX_WIDTH-1:0] idx
  );
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/request_encoder_16_4_rr_pick_16.sv
// Rotate-scan-unrotate priority picker: first set bit of vec at or
// above ptr, wrapping 15 -> 0. Ports: vec, ptr in; idx, found out.
module rr_pick_16
  import request_encoder_16_4_pkg::*;
(
  input  logic [REQ_WIDTH-1:0] vec,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 found
);

  logic [REQ_WIDTH-1:0] w_rot;
  logic [IDX_WIDTH-1:0] w_k;

  // bit 0 of w_rot is vec[ptr]
  assign w_rot = 16'({vec, vec} >> ptr);

  always_comb begin
    w_k = '0;
    for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_k = 4'(i);
    end
  end

  assign idx   = ptr + w_k;
  assign found = |vec;

endmodule

// File: rtl/request_encoder_16_4.sv
// Sticky 16-line request collector serialised to a 4-bit index on a
// valid/ready handshake. Ports: clock, clear, req_in, enc_ready in;
// enc_out, enc_valid, enc_onehot, pending, any_pending out.
module request_encoder_16_4
  import request_encoder_16_4_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [REQ_WIDTH-1:0] req_in,
  input  logic                 enc_ready,
  output logic [IDX_WIDTH-1:0] enc_out,
  output logic                 enc_valid,
  output logic [REQ_WIDTH-1:0] enc_onehot,
  output logic [REQ_WIDTH-1:0] pending,
  output logic                 any_pending
);

  logic [REQ_WIDTH-1:0] r_pending;
  logic [IDX_WIDTH-1:0] r_out;
  logic [IDX_WIDTH-1:0] r_ptr;
  logic                 r_valid;

  logic                 w_grant;
  logic                 w_load;
  logic [REQ_WIDTH-1:0] w_gbit;
  logic [REQ_WIDTH-1:0] w_next;
  logic [IDX_WIDTH-1:0] w_ptr_nx;
  logic [IDX_WIDTH-1:0] w_pick_ptr;
  logic [IDX_WIDTH-1:0] w_idx;
  logic                 w_found;

  assign w_grant = r_valid & enc_ready;
  assign w_load  = ~r_valid | enc_ready;
  assign w_gbit  = w_grant ? onehot16(r_out) : '0;

  // set wins over the grant clear on the same bit
  assign w_next  = (r_pending & ~w_gbit) | req_in;

  assign w_ptr_nx = w_grant ? r_out + 4'd1 : r_ptr;

  // scan from the post-grant pointer so the just-granted
  // index gets lowest priority on this very load
  assign w_pick_ptr = ROUND_ROBIN ? w_ptr_nx : '0;

  rr_pick_16 u_pick (
    .vec   (w_next),
    .ptr   (w_pick_ptr),
    .idx   (w_idx),
    .found (w_found)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_pending <= '0;
      r_out     <= '0;
      r_ptr     <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_pending <= w_next;
      r_ptr     <= w_ptr_nx;
      if (w_load) begin
        r_valid <= w_found;
        r_out   <= w_idx;
      end
    end
  end

  assign enc_out     = r_out;
  assign enc_valid   = r_valid;
  assign enc_onehot  = r_valid ? onehot16(r_out) : '0;
  assign pending     = r_pending;
  assign any_pending = |r_pending;

endmodule

// File: tb/tb_request_encoder_16_4.sv
// Bench for request_encoder_16_4: directed cases plus random traffic
// checked against a reference model, both priority modes side by side.
module tb_request_encoder_16_4;

  logic        clock;
  logic        clear;
  logic [15:0] req_in;
  logic        enc_ready;

  logic [3:0]  fx_out, rr_out;
  logic        fx_val, rr_val;
  logic [15:0] fx_oh, rr_oh;
  logic [15:0] fx_pend, rr_pend;
  logic        fx_any, rr_any;

  int n_chk;
  int n_fail;

  logic [15:0] m_pend [2];
  logic        m_valid[2];
  int          m_out  [2];
  int          m_ptr  [2];

  request_encoder_16_4 #(.ROUND_ROBIN(1'b0)) u_fx (
    .clock       (clock),
    .clear       (clear),
    .req_in      (req_in),
    .enc_ready   (enc_ready),
    .enc_out     (fx_out),
    .enc_valid   (fx_val),
    .enc_onehot  (fx_oh),
    .pending     (fx_pend),
    .any_pending (fx_any)
  );

  request_encoder_16_4 #(.ROUND_ROBIN(1'b1)) u_rr (
    .clock       (clock),
    .clear       (clear),
    .req_in      (req_in),
    .enc_ready   (enc_ready),
    .enc_out     (rr_out),
    .enc_valid   (rr_val),
    .enc_onehot  (rr_oh),
    .pending     (rr_pend),
    .any_pending (rr_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // first set index scanning upward from base, wrapping
  function automatic int pick(input logic [15:0] v, input int base);
    for (int k = 0; k < 16; k++) begin
      if (v[(base + k) % 16]) return (base + k) % 16;
    end
    return 0;
  endfunction

  task automatic model_edge(
    input logic [15:0] rq,
    input logic        rd,
    input logic        cl
  );
    for (int m = 0; m < 2; m++) begin
      if (cl) begin
        m_pend[m]  = '0;
        m_valid[m] = 1'b0;
        m_out[m]   = 0;
        m_ptr[m]   = 0;
      end else begin
        logic [15:0] np;
        logic        g;
        g  = m_valid[m] && rd;
        np = m_pend[m];
        if (g) begin
          np[m_out[m]] = 1'b0;
          m_ptr[m] = (m_out[m] + 1) % 16;
        end
        np = np | rq;
        if (!m_valid[m] || rd) begin
          m_valid[m] = (np != 0);
          m_out[m]   = pick(np, (m == 1) ? m_ptr[m] : 0);
        end
        m_pend[m] = np;
      end
    end
  endtask

  task automatic cmp_inst(
    input string       nm,
    input int          m,
    input logic [3:0]  o,
    input logic        v,
    input logic [15:0] oh,
    input logic [15:0] pd,
    input logic        ap
  );
    logic [15:0] exp_oh;
    exp_oh = m_valid[m] ? (16'h1 << m_out[m]) : 16'h0;
    chk({nm, ".valid"}, 32'(v), 32'(m_valid[m]));
    chk({nm, ".pending"}, 32'(pd), 32'(m_pend[m]));
    chk({nm, ".any"}, 32'(ap), 32'(m_pend[m] != 0));
    chk({nm, ".onehot"}, 32'(oh), 32'(exp_oh));
    if (m_valid[m])
      chk({nm, ".out"}, 32'(o), 32'(m_out[m]));
  endtask

  task automatic step(
    input logic [15:0] rq,
    input logic        rd,
    input logic        cl
  );
    req_in    = rq;
    enc_ready = rd;
    clear     = cl;
    model_edge(rq, rd, cl);
    @(posedge clock);
    @(negedge clock);
    cmp_inst("fx", 0, fx_out, fx_val, fx_oh, fx_pend, fx_any);
    cmp_inst("rr", 1, rr_out, rr_val, rr_oh, rr_pend, rr_any);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    clear     = 1'b1;
    req_in    = '0;
    enc_ready = 1'b0;

    step(16'h0, 1'b0, 1'b1);
    chk("rst.rr_valid", 32'(rr_val), 32'd0);
    chk("rst.rr_pend", 32'(rr_pend), 32'd0);

    // reset mid-operation
    step(16'hFFFF, 1'b0, 1'b0);
    chk("midrst.pre_valid", 32'(rr_val), 32'd1);
    step(16'h0001, 1'b1, 1'b1);
    chk("midrst.pend", 32'(rr_pend), 32'd0);
    chk("midrst.valid", 32'(rr_val), 32'd0);
    chk("midrst.out", 32'(rr_out), 32'd0);
    chk("midrst.fx_pend", 32'(fx_pend), 32'd0);
    step(16'h0, 1'b0, 1'b0);
    chk("midrst.idle", 32'(rr_val), 32'd0);

    // single request
    step(16'h0200, 1'b1, 1'b0);
    chk("single.valid", 32'(rr_val), 32'd1);
    chk("single.out", 32'(rr_out), 32'h9);
    chk("single.onehot", 32'(rr_oh), 32'h0200);
    step(16'h0, 1'b1, 1'b0);
    chk("single.pend", 32'(rr_pend), 32'd0);
    chk("single.drain", 32'(rr_val), 32'd0);

    // stall stability
    step(16'h0080, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(16'h0, 1'b0, 1'b0);
    step(16'h0001, 1'b0, 1'b0);
    chk("stall.rr_out", 32'(rr_out), 32'h7);
    chk("stall.fx_out", 32'(fx_out), 32'h7);
    step(16'h0, 1'b1, 1'b0);
    chk("stall.next_rr", 32'(rr_out), 32'h0);
    chk("stall.next_fx", 32'(fx_out), 32'h0);
    step(16'h0, 1'b1, 1'b0);

    // round-robin rotation from a fresh pointer
    step(16'h0, 1'b0, 1'b1);
    step(16'hFFFF, 1'b1, 1'b0);
    chk("rot.0", 32'(rr_out), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(16'h0, 1'b1, 1'b0);
      chk($sformatf("rot.%0d", i), 32'(rr_out), 32'(i));
    end
    step(16'h0, 1'b1, 1'b0);
    chk("rot.done", 32'(rr_val), 32'd0);
    step(16'h8001, 1'b1, 1'b0);
    chk("wrap.first", 32'(rr_out), 32'd0);
    step(16'h0, 1'b1, 1'b0);
    chk("wrap.second", 32'(rr_out), 32'd15);
    step(16'h0, 1'b1, 1'b0);

    // fixed priority starves index 15
    step(16'h8001, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(16'h0001, 1'b1, 1'b0);
      chk("fixed.out", 32'(fx_out), 32'd0);
    end
    chk("fixed.starved", 32'(fx_pend[15]), 32'd1);
    step(16'h0, 1'b0, 1'b1);

    // set-wins collision
    step(16'h0008, 1'b1, 1'b0);
    chk("setwin.pre", 32'(rr_out), 32'h3);
    step(16'h0008, 1'b1, 1'b0);
    chk("setwin.pend3", 32'(rr_pend[3]), 32'd1);
    chk("setwin.valid", 32'(rr_val), 32'd1);
    chk("setwin.out", 32'(rr_out), 32'h3);
    chk("setwin.fx_out", 32'(fx_out), 32'h3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rq;
      case ($urandom_range(0, 3))
        0:       rq = 16'h0;
        1:       rq = 16'($urandom);
        2:       rq = 16'h1 << $urandom_range(0, 15);
        default: rq = 16'($urandom & $urandom & $urandom);
      endcase
      step(rq,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
